// File: rtl/packet_streamer_core.sv
// packet_streamer_core: byte-wide Ethernet TX framer for the sample-streaming path.
// Source words are queued in a FIFO as {end,word}. Each completed block becomes one data
// frame. A rising edge on cmd_ready inserts a 64-byte command frame read from an external
// RAM, and it takes priority over queued data.
// Build option: define PACKET_STREAMER_FCS_EN to append a CRC-32 FCS to every frame.
// Without it the frame ends after the last payload/pad/command byte and the MAC adds the FCS.
module packet_streamer_core #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [47:0] DEST_MAC  = 48'hFFFFFFFFFFFF,
    parameter int          FIFO_AW   = 9,
    parameter int          IFG       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] source_data,
    input  logic        source_en,
    input  logic        source_packet_end,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_ctl,
    output logic [15:0] packet_count,
    input  logic        streamer_enable,
    input  logic [47:0] mac_addr,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_addr,
    input  logic [7:0]  cmd_data
);
    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0] GAP_LAST = 16'(IFG - 1);
    localparam logic [15:0] MIN_LAST = 16'd59;   // index of byte 60 counted from the destination MAC

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP} state_t;
    state_t state;

    logic [16:0]      fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic [16:0]      fifo_head;
    logic             fifo_full, fifo_empty, fifo_wr, fifo_rd, wr_end;
    logic [15:0]      blk_cnt;
    logic             cmd_q, cmd_pend, cmd_rise, in_cmd_frame;
    logic             is_cmd, tx_en, lo, last_w;
    logic [7:0]       tx_byte;
    logic [15:0]      cnt;
    logic             can_start, start_cmd, start_data, pay_done;
    state_t           end_state;
    logic [7:0]       end_byte;
    logic             end_en;

    // Byte idx of the header {DEST_MAC, source MAC, EtherType, frame number}, MSB first
    function automatic logic [7:0] hdr_byte(input logic [47:0] src, input logic [15:0] pcnt,
                                            input logic [3:0] idx);
        logic [127:0] hdr;
        hdr = {DEST_MAC, src, ETHERTYPE, pcnt} << {idx, 3'b000};
        return hdr[127:120];
    endfunction

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_full  = fifo_cnt[FIFO_AW];
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign fifo_wr    = source_en & streamer_enable & ~fifo_full;
    // An end marker is counted even when its word is dropped, so a block is never lost
    assign wr_end     = source_en & streamer_enable & source_packet_end;
    assign fifo_rd    = (state == S_PAY) && !lo;

    // Payload ends on the flagged word, or when the FIFO runs dry (end word was dropped)
    assign pay_done = ((state == S_HDR) && (cnt == 16'd15) && fifo_empty) ||
                      ((state == S_PAY) && lo && (last_w || fifo_empty));

    assign cmd_rise     = cmd_ready & ~cmd_q;
    assign in_cmd_frame = is_cmd && (state != S_IDLE);
    assign can_start    = (state == S_IDLE) || ((state == S_GAP) && (cnt == GAP_LAST));
    assign start_cmd    = can_start && cmd_pend;
    assign start_data   = can_start && !cmd_pend && streamer_enable && (blk_cnt != '0);

    // Command bytes come straight from the RAM so cmd_addr leads tx_data by exactly one cycle
    assign tx_data = (state == S_CMD) ? cmd_data : tx_byte;
    assign tx_ctl  = {tx_en, tx_en};

`ifdef PACKET_STREAMER_FCS_EN
    logic [31:0] crc_r, crc_upd, fcs_next;
    logic        in_crc;

    // One byte of reflected CRC-32 (poly 04C11DB7 reversed)
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign in_crc    = (state == S_CMD) || (state == S_HDR) || (state == S_PAY) || (state == S_PAD);
    assign crc_upd   = in_crc ? crc_byte(crc_r, tx_data) : crc_r;
    assign fcs_next  = ~crc_upd >> {cnt[1:0] + 2'd1, 3'b000};
    assign end_state = S_FCS;
    assign end_byte  = ~crc_upd[7:0];
    assign end_en    = 1'b1;

    // CRC register: seeded during the preamble, accumulates every byte currently on tx_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              crc_r <= '1;
        else if (state == S_PRE) crc_r <= '1;
        else                     crc_r <= crc_upd;
    end
`else
    assign end_state = S_GAP;
    assign end_byte  = 8'd0;
    assign end_en    = 1'b0;
`endif

    // FIFO storage, data only
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {source_packet_end, source_data};
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
            if (fifo_rd) rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
        end
    end

    // Complete blocks waiting in the FIFO; simultaneous arrival and consumption cancel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      blk_cnt <= '0;
        else if (wr_end && !pay_done)                    blk_cnt <= blk_cnt + 16'd1;
        else if (!wr_end && pay_done && blk_cnt != '0)   blk_cnt <= blk_cnt - 16'd1;
    end

    // cmd_ready edge detect; a request is held until its frame starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q    <= 1'b0;
            cmd_pend <= 1'b0;
        end else begin
            cmd_q <= cmd_ready;
            if (start_cmd)                         cmd_pend <= 1'b0;
            else if (cmd_rise && !in_cmd_frame)    cmd_pend <= 1'b1;
        end
    end

    // Frame sequencer: state and cnt describe the byte currently on tx_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            tx_byte      <= '0;
            tx_en        <= 1'b0;
            cnt          <= '0;
            is_cmd       <= 1'b0;
            lo           <= 1'b0;
            last_w       <= 1'b0;
            cmd_addr     <= '0;
            packet_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    tx_byte <= '0;
                    tx_en   <= 1'b0;
                    if (start_cmd || start_data) begin
                        state    <= S_PRE;
                        tx_byte  <= 8'h55;
                        tx_en    <= 1'b1;
                        cnt      <= '0;
                        is_cmd   <= start_cmd;
                        cmd_addr <= '0;
                    end else if (state == S_GAP) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == GAP_LAST) state <= S_IDLE;
                    end
                end
                S_PRE: begin
                    if (cnt == 16'd7) begin
                        cnt <= '0;
                        if (is_cmd) begin
                            state    <= S_CMD;
                            cmd_addr <= cmd_addr + 6'd1;
                        end else begin
                            state   <= S_HDR;
                            tx_byte <= hdr_byte(mac_addr, packet_count, 4'd0);
                        end
                    end else begin
                        cnt     <= cnt + 16'd1;
                        tx_byte <= (cnt == 16'd6) ? 8'hD5 : 8'h55;
                    end
                end
                S_CMD: begin
                    if (cnt == 16'd63) begin
                        state   <= end_state;
                        tx_byte <= end_byte;
                        tx_en   <= end_en;
                        cnt     <= '0;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        cmd_addr <= cmd_addr + 6'd1;
                    end
                end
                S_HDR: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'd15) begin
                        if (fifo_empty) begin
                            state        <= S_PAD;
                            tx_byte      <= '0;
                            packet_count <= packet_count + 16'd1;
                        end else begin
                            state   <= S_PAY;
                            tx_byte <= fifo_head[15:8];
                            lo      <= 1'b0;
                        end
                    end else begin
                        tx_byte <= hdr_byte(mac_addr, packet_count, cnt[3:0] + 4'd1);
                    end
                end
                S_PAY: begin
                    cnt <= cnt + 16'd1;
                    if (!lo) begin
                        tx_byte <= fifo_head[7:0];
                        lo      <= 1'b1;
                        last_w  <= fifo_head[16];
                    end else if (last_w || fifo_empty) begin
                        packet_count <= packet_count + 16'd1;
                        if (cnt < MIN_LAST) begin
                            state   <= S_PAD;
                            tx_byte <= '0;
                        end else begin
                            state   <= end_state;
                            tx_byte <= end_byte;
                            tx_en   <= end_en;
                            cnt     <= '0;
                        end
                    end else begin
                        tx_byte <= fifo_head[15:8];
                        lo      <= 1'b0;
                    end
                end
                S_PAD: begin
                    if (cnt >= MIN_LAST) begin
                        state   <= end_state;
                        tx_byte <= end_byte;
                        tx_en   <= end_en;
                        cnt     <= '0;
                    end else begin
                        cnt     <= cnt + 16'd1;
                        tx_byte <= '0;
                    end
                end
`ifdef PACKET_STREAMER_FCS_EN
                S_FCS: begin
                    if (cnt == 16'd3) begin
                        state   <= S_GAP;
                        tx_byte <= '0;
                        tx_en   <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt     <= cnt + 16'd1;
                        tx_byte <= fcs_next[7:0];
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    tx_byte <= '0;
                    tx_en   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_packet_streamer_core.sv
// tb_packet_streamer_core: directed bench for packet_streamer_core. Frames are captured byte
// by byte on the falling edge and compared against hand-built expected frames.
module tb_packet_streamer_core;
`ifdef PACKET_STREAMER_FCS_EN
    localparam int FCS_B = 4;
`else
    localparam int FCS_B = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] source_data;
    logic        source_en;
    logic        source_packet_end;
    logic [7:0]  tx_data;
    logic [1:0]  tx_ctl;
    logic [15:0] packet_count;
    logic        streamer_enable;
    logic [47:0] mac_addr;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;

    logic [7:0]  ram  [64];
    logic [7:0]  fb   [4096];
    logic [7:0]  expb [2048];
    int          flen, idle, ctl_bad, hi;
    int          checks = 0;
    int          errors = 0;

    packet_streamer_core dut (
        .clk(clk), .reset(reset), .source_data(source_data), .source_en(source_en),
        .source_packet_end(source_packet_end), .tx_data(tx_data), .tx_ctl(tx_ctl),
        .packet_count(packet_count), .streamer_enable(streamer_enable), .mac_addr(mac_addr),
        .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data)
    );

    always #5 clk = ~clk;

    // Command RAM with one cycle of read latency
    always @(posedge clk) cmd_data <= ram[cmd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Wait (bounded) for TX_EN, then record every byte while it stays high
    task automatic get_frame(input int budget);
        for (int i = 0; i < 4096; i++) fb[i] = 'x;
        flen = 0; idle = 0; ctl_bad = 0;
        while (tx_ctl[0] !== 1'b1 && idle < budget) begin
            idle++;
            @(negedge clk);
        end
        while (tx_ctl[0] === 1'b1 && flen < 4000) begin
            if (tx_ctl !== 2'b11) ctl_bad++;
            fb[flen] = tx_data;
            flen++;
            @(negedge clk);
        end
    endtask

    task automatic count_tx(input int n);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_ctl !== 2'b00) hi++;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic e);
        source_data = d; source_en = 1'b1; source_packet_end = e;
        @(negedge clk);
        source_en = 1'b0; source_packet_end = 1'b0;
    endtask

    task automatic set_hdr(input logic [15:0] pcnt);
        for (int i = 0; i < 2048; i++) expb[i] = 8'h00;
        for (int i = 0; i < 6; i++) expb[i] = 8'hFF;
        expb[6] = 8'h00; expb[7] = 8'h01; expb[8] = 8'h02;
        expb[9] = 8'h03; expb[10] = 8'h04; expb[11] = 8'h09;
        expb[12] = 8'h88; expb[13] = 8'hB5;
        expb[14] = pcnt[15:8]; expb[15] = pcnt[7:0];
    endtask

`ifdef PACKET_STREAMER_FCS_EN
    // Running CRC over data plus its FCS leaves the fixed Ethernet residue
    function automatic logic [31:0] crc_reg(input int first, input int n);
        logic [31:0] c;
        c = '1;
        for (int i = first; i < first + n; i++) begin
            c = c ^ {24'd0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    task automatic check_frame(input string tag, input int body_len);
        int bad;
        chk({tag, "_len"}, flen, 8 + body_len + FCS_B);
        chk({tag, "_ctl"}, ctl_bad, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (fb[i] !== ((i == 7) ? 8'hD5 : 8'h55)) bad++;
        chk({tag, "_preamble"}, bad, 0);
        bad = 0;
        for (int i = 0; i < body_len; i++) if (fb[8+i] !== expb[i]) bad++;
        chk({tag, "_body"}, bad, 0);
`ifdef PACKET_STREAMER_FCS_EN
        chk({tag, "_fcs"}, crc_reg(8, body_len + 4), 32'hDEBB20E3);
`endif
    endtask

    initial begin
        reset = 1'b0; source_data = '0; source_en = 1'b0; source_packet_end = 1'b0;
        streamer_enable = 1'b0; mac_addr = 48'h000102030409; cmd_ready = 1'b0;
        ram[0] = 8'hC8; ram[1] = 8'h1F; ram[2] = 8'h66; ram[3] = 8'h23;
        ram[4] = 8'hD7; ram[5] = 8'h36; ram[6] = 8'h00; ram[7] = 8'h01;
        for (int i = 8; i < 64; i++) ram[i] = 8'(i * 7 + 3);

        // Reset held for 9 cycles
        repeat (9) @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_ctl", tx_ctl, 2'b00);
        chk("rst_packet_count", packet_count, 16'h0000);
        chk("rst_cmd_addr", cmd_addr, 6'd0);
        reset = 1'b1;
        count_tx(30);
        chk("idle_quiet", hi, 0);

        // Single command frame; cmd_ready stays high well past 30 cycles
        cmd_ready = 1'b1;
        get_frame(50);
        for (int i = 0; i < 64; i++) expb[i] = ram[i];
        check_frame("cmd1", 64);
        count_tx(150);
        chk("cmd1_single", hi, 0);
        cmd_ready = 1'b0;
        chk("cmd1_pcnt", packet_count, 16'd0);

        // Basic data frame, 4 words, padded to 60 bytes
        streamer_enable = 1'b1;
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        send_word(16'h9ABC, 1'b0);
        send_word(16'hDEF0, 1'b1);
        get_frame(50);
        set_hdr(16'd0);
        expb[16] = 8'h12; expb[17] = 8'h34; expb[18] = 8'h56; expb[19] = 8'h78;
        expb[20] = 8'h9A; expb[21] = 8'hBC; expb[22] = 8'hDE; expb[23] = 8'hF0;
        check_frame("data1", 60);
        chk("data1_pcnt", packet_count, 16'd1);
        streamer_enable = 1'b0;
        count_tx(20);

        // Queue a block during a command frame, then disable: only the command frame goes out
        cmd_ready = 1'b1;
        streamer_enable = 1'b1;
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBB55, 1'b1);
        streamer_enable = 1'b0;
        get_frame(20);
        for (int i = 0; i < 64; i++) expb[i] = ram[i];
        check_frame("cmd2", 64);
        cmd_ready = 1'b0;
        count_tx(150);
        chk("disabled_no_data", hi, 0);
        chk("disabled_pcnt", packet_count, 16'd1);

        // Command request and re-enable together: command first, data after IFG
        cmd_ready = 1'b1;
        @(negedge clk);
        streamer_enable = 1'b1;
        @(negedge clk);
        get_frame(20);
        for (int i = 0; i < 64; i++) expb[i] = ram[i];
        check_frame("cmd3", 64);
        get_frame(40);
        chk("ifg_idle", idle, 12);
        set_hdr(16'd1);
        expb[16] = 8'hAA; expb[17] = 8'hAA; expb[18] = 8'hBB; expb[19] = 8'h55;
        check_frame("data2", 60);
        chk("data2_pcnt", packet_count, 16'd2);
        cmd_ready = 1'b0;
        count_tx(20);

        // FIFO overflow: 520 words without end, then an end marker that is itself dropped
        for (int i = 0; i < 520; i++) send_word(16'(16'h0100 + i), 1'b0);
        send_word(16'hEEEE, 1'b1);
        get_frame(50);
        set_hdr(16'd2);
        for (int i = 0; i < 512; i++) begin
            expb[16 + 2*i] = 8'(9'h100 + i >> 8);
            expb[17 + 2*i] = 8'(i);
        end
        check_frame("ovf", 16 + 1024);
        chk("ovf_pcnt", packet_count, 16'd3);
        count_tx(40);
        chk("ovf_no_extra", hi, 0);

        // After overflow the framer still produces exactly one frame per block
        send_word(16'h4242, 1'b1);
        get_frame(50);
        set_hdr(16'd3);
        expb[16] = 8'h42; expb[17] = 8'h42;
        check_frame("post_ovf", 60);
        chk("post_ovf_pcnt", packet_count, 16'd4);
        count_tx(100);
        chk("post_ovf_quiet", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
